// File: rtl/riscv_mem_ctrl.sv
// riscv_mem_ctrl: single-port word memory behind a fixed-latency request/response
// handshake. Each access is accepted in IDLE, waits WAIT_CYCLES cycles and
// completes in a one-cycle RESP state. Writes commit on the edge leaving RESP.
//
// Optional feature macro: MEMCTRL_ALIGN_CHECK_EN
//   defined   -> rsp_err port present; accesses with addr[1:0] != 0 complete
//                with rsp_err=1, read data 0 and no array write.
//   undefined -> no rsp_err port; addr[1:0] ignored.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new access (req_ready=1)
// WAIT  | access latched, counting down the wait states
// RESP  | single completion cycle: rsp_valid=1, read data driven

module riscv_mem_ctrl #(
   parameter int BIT_WIDTH   = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [BIT_WIDTH-1:0] req_addr,
   input  logic [BIT_WIDTH-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic [BIT_WIDTH-1:0] rsp_rdata
`ifdef MEMCTRL_ALIGN_CHECK_EN
   ,
   output logic                 rsp_err
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Loaded on accept so that WAIT lasts exactly WAIT_CYCLES cycles.
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [3:0]             r_cnt;
   logic [3:0]             w_next_cnt;
   logic                   w_accept;

   logic                   r_we;
   logic [BIT_WIDTH-1:0]   r_addr;
   logic [BIT_WIDTH-1:0]   r_wdata;

   logic                   w_in_range;
   logic                   w_misalign;
   logic                   w_mem_ok;
   logic [AW-1:0]          w_idx;

   // Zero at time 0 for simulation; deliberately not touched by reset.
   logic [BIT_WIDTH-1:0]   r_mem [DEPTH] = '{default: '0};

   assign req_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign w_accept  = req_valid && (r_state == IDLE);

   // Out-of-range indices are compared on the full word index, not the
   // truncated array index, so 0x1000 does not alias onto word 0.
   assign w_in_range = ({2'b00, r_addr[BIT_WIDTH-1:2]} < BIT_WIDTH'(DEPTH));
   assign w_idx      = r_addr[AW+1:2];

`ifdef MEMCTRL_ALIGN_CHECK_EN
   assign w_misalign = (r_addr[1:0] != 2'b00);
   assign rsp_err    = (r_state == RESP) && w_misalign;
`else
   logic w_unused_addr_lsb;
   assign w_misalign        = 1'b0;
   assign w_unused_addr_lsb = ^r_addr[1:0];
`endif

   assign w_mem_ok = w_in_range && !w_misalign;

   // State and wait-counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES > 0) begin
                  w_next_state = WAIT;
                  w_next_cnt   = CNT_LOAD;
               end else begin
                  w_next_state = RESP;
               end
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_next_state = RESP;
            end else begin
               w_next_cnt = r_cnt - 4'd1;
            end
         end
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Capture the request on accept so later input changes cannot disturb it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_we    <= req_we;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
      end
   end

   // Read data is only driven for a valid read during RESP.
   always_comb begin
      rsp_rdata = '0;
      if ((r_state == RESP) && !r_we && w_mem_ok) begin
         rsp_rdata = r_mem[w_idx];
      end
   end

   // Write commits on the edge leaving RESP; a reset beforehand drops it.
   always_ff @(posedge clk) begin
      if ((r_state == RESP) && r_we && w_mem_ok) begin
         r_mem[w_idx] <= r_wdata;
      end
   end

endmodule

// File: tb/tb_riscv_mem_ctrl.sv
// Testbench for riscv_mem_ctrl: one instance with WAIT_CYCLES=0 and one with
// WAIT_CYCLES=2, sharing clock, reset and request buses; each has its own
// req_valid. Table-driven accesses plus hand-written multi-cycle sequences.
module tb_riscv_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid0 = 1'b0;
   logic        req_valid2 = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready0, req_ready2;
   logic        rsp_valid0, rsp_valid2;
   logic [31:0] rsp_rdata0, rsp_rdata2;
`ifdef MEMCTRL_ALIGN_CHECK_EN
   logic        rsp_err0, rsp_err2;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   riscv_mem_ctrl #(.BIT_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0)
`ifdef MEMCTRL_ALIGN_CHECK_EN
      , .rsp_err(rsp_err0)
`endif
   );

   riscv_mem_ctrl #(.BIT_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2)
`ifdef MEMCTRL_ALIGN_CHECK_EN
      , .rsp_err(rsp_err2)
`endif
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          chk_rd;
      logic [31:0] exp_rd;
      string       name;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic get_ready(input bit sel);
      return sel ? req_ready0 : req_ready2;
   endfunction

   function automatic logic get_valid(input bit sel);
      return sel ? rsp_valid0 : rsp_valid2;
   endfunction

   function automatic logic [31:0] get_rdata(input bit sel);
      return sel ? rsp_rdata0 : rsp_rdata2;
   endfunction

   function automatic logic get_err(input bit sel);
`ifdef MEMCTRL_ALIGN_CHECK_EN
      return sel ? rsp_err0 : rsp_err2;
`else
      return sel ? 1'b0 : 1'b0;
`endif
   endfunction

   // sel=1 -> dut0 (WAIT_CYCLES=0), sel=0 -> dut2 (WAIT_CYCLES=2).
   // Inputs are scrambled right after accept to prove they were latched.
   task automatic access(input bit sel, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_lat,
                         input bit chk_rd, input logic [31:0] exp_rd,
                         input string name, output logic err);
      int lat;
      @(negedge clk);
      chk({name, "_ready_pre"}, 32'(get_ready(sel)), 32'd1);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      if (sel) req_valid0 = 1'b1; else req_valid2 = 1'b1;
      @(posedge clk);
      #1;
      req_valid0 = 1'b0;
      req_valid2 = 1'b0;
      req_we     = ~we;
      req_addr   = ~addr;
      req_wdata  = ~wdata;
      lat = 1;
      while (!get_valid(sel) && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "_ready_busy"}, 32'(get_ready(sel)), 32'd0);
      err = get_err(sel);
      if (chk_rd) chk({name, "_rdata"}, get_rdata(sel), exp_rd);
      @(posedge clk);
      #1;
      chk({name, "_valid_post"}, 32'(get_valid(sel)), 32'd0);
      chk({name, "_ready_post"}, 32'(get_ready(sel)), 32'd1);
      chk({name, "_rdata_post"}, get_rdata(sel), 32'd0);
      chk({name, "_err_post"}, 32'(get_err(sel)), 32'd0);
      req_we = 1'b0;
   endtask

   initial begin
      logic err;
      int   acc_n, acc_first, pul_n;
      int   pul_cyc[$];

      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          "wr_10"};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, "rd_10"};
      vecs[2]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 32'h0,          "wr_14"};
      vecs[3]  = '{1'b0, 32'h0000_0014, 32'h0,         1'b1, 32'h1234_5678, "rd_14"};
      vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, "rd_10_again"};
      vecs[5]  = '{1'b1, 32'h0000_1000, 32'h0000_1234, 1'b0, 32'h0,          "wr_oor"};
      vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0,          "rd_oor"};
      vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0,          "rd_0_after_oor"};
      vecs[8]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0,          "wr_last"};
      vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'hCAFE_F00D, "rd_last"};
      vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, "rd_10_after_last"};
`ifdef MEMCTRL_ALIGN_CHECK_EN
      vecs[11] = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0,          "rd_12_misaligned"};
`else
      vecs[11] = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'hDEAD_BEEF, "rd_12_lsb_ignored"};
`endif

      // Reset state
      #12;
      chk("rst_ready2", 32'(req_ready2), 32'd1);
      chk("rst_valid2", 32'(rsp_valid2), 32'd0);
      chk("rst_rdata2", rsp_rdata2, 32'd0);
      chk("rst_ready0", 32'(req_ready0), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      // WAIT_CYCLES=0: read after reset, then write/read
      access(1'b1, 1'b0, 32'h0,  32'h0,        1, 1'b1, 32'h0,        "w0_rd_0",  err);
      access(1'b1, 1'b1, 32'h20, 32'h0000_55AA, 1, 1'b0, 32'h0,        "w0_wr_20", err);
      access(1'b1, 1'b0, 32'h20, 32'h0,        1, 1'b1, 32'h0000_55AA, "w0_rd_20", err);

      // WAIT_CYCLES=2: table of accesses
      for (int i = 0; i < 12; i++) begin
         access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, 3,
                vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].name, err);
      end

      // Reset pulsed during WAIT aborts the write to 0x8
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hA5A5_A5A5; req_valid2 = 1'b1;
      @(posedge clk);
      #1;
      req_valid2 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_ready_in_reset", 32'(req_ready2), 32'd1);
      chk("abort_valid_in_reset", 32'(rsp_valid2), 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_ready_after_reset", 32'(req_ready2), 32'd1);
      req_we = 1'b0;
      access(1'b0, 1'b0, 32'h8, 32'h0, 3, 1'b1, 32'h0, "abort_rd_8", err);

      // req_valid held high: cycle 0 primes an access, then cycles 2..11 held
      acc_n = 0; acc_first = -1; pul_n = 0;
      req_we = 1'b0; req_addr = 32'h10;
      @(negedge clk);
      for (int c = 0; c < 15; c++) begin
         req_valid2 = (c == 0) || (c >= 2 && c <= 11);
         if (c == 0) chk("held_ready_c0", 32'(req_ready2), 32'd1);
         if (c == 3) chk("held_prior_pulse_c3", 32'(rsp_valid2), 32'd1);
         if (c >= 2 && req_valid2 && req_ready2) begin
            acc_n++;
            if (acc_first < 0) acc_first = c;
         end
         if (rsp_valid2) begin
            chk("held_rdata", rsp_rdata2, 32'hDEAD_BEEF);
            if (c > 3) begin
               pul_n++;
               pul_cyc.push_back(c);
            end
         end
         @(negedge clk);
      end
      req_valid2 = 1'b0;
      chk("held_accepts", 32'(acc_n), 32'd2);
      chk("held_first_accept_cycle", 32'(acc_first), 32'd4);
      chk("held_pulses", 32'(pul_n), 32'd2);
      if (pul_cyc.size() == 2) chk("held_pulse_spacing", 32'(pul_cyc[1] - pul_cyc[0]), 32'd4);
      else chk("held_pulse_spacing", 32'hFFFF_FFFF, 32'd4);

`ifdef MEMCTRL_ALIGN_CHECK_EN
      // Misaligned write flags an error and leaves word 1 (0x4) intact
      access(1'b0, 1'b1, 32'h4, 32'h1111_2222, 3, 1'b0, 32'h0, "al_wr_4", err);
      chk("al_wr_4_err", 32'(err), 32'd0);
      access(1'b0, 1'b1, 32'h6, 32'h0000_00FF, 3, 1'b0, 32'h0, "al_wr_6", err);
      chk("al_wr_6_err", 32'(err), 32'd1);
      access(1'b0, 1'b0, 32'h4, 32'h0, 3, 1'b1, 32'h1111_2222, "al_rd_4", err);
      chk("al_rd_4_err", 32'(err), 32'd0);
      access(1'b0, 1'b0, 32'h6, 32'h0, 3, 1'b1, 32'h0, "al_rd_6", err);
      chk("al_rd_6_err", 32'(err), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
